// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the fetch-side predictor and the execute-stage redirect logic.
package branch_predictor_pkg;

  localparam int BP_INDEX_BITS = 4;

  typedef enum logic [2:0] {
    NEXT_PC  = 3'd0,
    EQ_TRUE  = 3'd1,
    EQ_FALSE = 3'd2,
    UC_JUMP  = 3'd3,
    JALR     = 3'd4
  } pcsrc_t;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute resolution and perf-counter signals between the pipeline and the predictor.
interface branch_predictor_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic [ADDRESS_WIDTH-1:0] PCF;
  logic                     PredTakenF;
  logic [ADDRESS_WIDTH-1:0] PredTargetF;
  logic                     ValidE;
  logic [2:0]               PCsrcE;
  logic [ADDRESS_WIDTH-1:0] PCE;
  logic [ADDRESS_WIDTH-1:0] PCPlus4E;
  logic [ADDRESS_WIDTH-1:0] PCTargetE;
  logic [ADDRESS_WIDTH-1:0] ALUResult;
  logic                     eq;
  logic                     PredTakenE;
  logic [ADDRESS_WIDTH-1:0] PredTargetE;
  logic                     MispredictE;
  logic [ADDRESS_WIDTH-1:0] RedirectPCE;
  logic [31:0]              BranchCount;
  logic [31:0]              MispredictCount;

  modport master (
    output PCF, ValidE, PCsrcE, PCE, PCPlus4E, PCTargetE, ALUResult, eq,
           PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE, RedirectPCE, BranchCount,
           MispredictCount
  );

  modport slave (
    input  PCF, ValidE, PCsrcE, PCE, PCPlus4E, PCTargetE, ALUResult, eq,
           PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE, RedirectPCE, BranchCount,
           MispredictCount
  );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating direction counter: next state from current state and resolved direction.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    taken,
  output bp_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    case (ctr)
      BP_SNT:  ctr_next = taken ? BP_WNT : BP_SNT;
      BP_WNT:  ctr_next = taken ? BP_WT  : BP_SNT;
      BP_WT:   ctr_next = taken ? BP_ST  : BP_WNT;
      BP_ST:   ctr_next = taken ? BP_ST  : BP_WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency fetch prediction, execute-stage
// mispredict/redirect, table training and branch/mispredict perf counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INDEX_BITS    = BP_INDEX_BITS,
  parameter int TAG_BITS      = ADDRESS_WIDTH - INDEX_BITS - 2
) (
  input logic                clk,
  input logic                rst_n,
  branch_predictor_if.slave  bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]       valid;
  bp_ctr_t                  ctr      [ENTRIES];
  logic [TAG_BITS-1:0]      tag_q    [ENTRIES];
  logic [ADDRESS_WIDTH-1:0] target_q [ENTRIES];
  logic [31:0]              branch_cnt;
  logic [31:0]              mispredict_cnt;

  logic [INDEX_BITS-1:0]    idx_f, idx_e;
  logic [TAG_BITS-1:0]      tag_f, tag_e;
  logic                     hit_f, hit_e, pred_taken_f;
  logic                     actual_taken, trains, counted, is_uc_jump, mispredict;
  logic [ADDRESS_WIDTH-1:0] actual_target;
  bp_ctr_t                  ctr_next;
  logic                     unused_pce_lsbs;

  assign unused_pce_lsbs = ^bus.PCE[1:0];

  assign idx_f = bus.PCF[INDEX_BITS+1:2];
  assign tag_f = bus.PCF[ADDRESS_WIDTH-1:INDEX_BITS+2];
  assign idx_e = bus.PCE[INDEX_BITS+1:2];
  assign tag_e = bus.PCE[ADDRESS_WIDTH-1:INDEX_BITS+2];

  // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
  assign hit_f        = valid[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_taken_f = hit_f && ctr[idx_f][1];
  assign hit_e        = valid[idx_e] && (tag_q[idx_e] == tag_e);

  assign bus.PredTakenF  = pred_taken_f;
  assign bus.PredTargetF = pred_taken_f ? target_q[idx_f] : bus.PCF + ADDRESS_WIDTH'(4);

  // Undefined PCsrcE encodings fall through to the NEXT_PC defaults.
  always_comb begin
    actual_taken  = 1'b0;
    actual_target = bus.PCTargetE;
    trains        = 1'b0;
    counted       = 1'b0;
    is_uc_jump    = 1'b0;
    case (bus.PCsrcE)
      EQ_TRUE:  begin actual_taken = bus.eq;  trains = 1'b1; counted = 1'b1; end
      EQ_FALSE: begin actual_taken = !bus.eq; trains = 1'b1; counted = 1'b1; end
      UC_JUMP:  begin actual_taken = 1'b1;    trains = 1'b1; counted = 1'b1; is_uc_jump = 1'b1; end
      JALR:     begin actual_taken = 1'b1;    actual_target = bus.ALUResult; counted = 1'b1; end
      default:  ;
    endcase
  end

  assign mispredict = bus.ValidE &&
                      ((actual_taken != bus.PredTakenE) ||
                       (actual_taken && (bus.PredTargetE != actual_target)));

  assign bus.MispredictE     = mispredict;
  assign bus.RedirectPCE     = actual_taken ? actual_target : bus.PCPlus4E;
  assign bus.BranchCount     = branch_cnt;
  assign bus.MispredictCount = mispredict_cnt;

  bp_sat_counter u_sat (
    .ctr      (ctr[idx_e]),
    .taken    (actual_taken),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid          <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= BP_WNT;
    end else begin
      if (bus.ValidE && trains) begin
        if (hit_e) begin
          ctr[idx_e] <= ctr_next;
        end else if (actual_taken) begin
          valid[idx_e] <= 1'b1;
          ctr[idx_e]   <= is_uc_jump ? BP_ST : BP_WT;
        end
      end
      if (bus.ValidE && counted) branch_cnt <= branch_cnt + 32'd1;
      if (mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

  // Tag/target payload is only meaningful behind valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (bus.ValidE && trains && actual_taken) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= actual_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: stimulus queues expectations, a negedge monitor checks them.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int AW = 32;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  localparam int S_PTAKEN = 0, S_PTARGET = 1, S_MISP = 2, S_REDIR = 3, S_BCNT = 4, S_MCNT = 5;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   fails;
  exp_t sbq[$];
  exp_t cur;
  logic [31:0] act;

  branch_predictor_if #(.ADDRESS_WIDTH(AW)) bus ();

  branch_predictor #(.ADDRESS_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] get_act(int sel);
    case (sel)
      S_PTAKEN:  return {31'd0, bus.PredTakenF};
      S_PTARGET: return bus.PredTargetF;
      S_MISP:    return {31'd0, bus.MispredictE};
      S_REDIR:   return bus.RedirectPCE;
      S_BCNT:    return bus.BranchCount;
      default:   return bus.MispredictCount;
    endcase
  endfunction

  // Monitor: every expectation tagged for this cycle is compared at the falling edge.
  initial begin
    checks = 0;
    fails  = 0;
  end

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      cur = sbq.pop_front();
      act = get_act(cur.sel);
      checks++;
      if (cur.cyc < cyc) begin
        fails++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", cur.name, cur.cyc, cyc);
      end else if (act !== cur.val) begin
        fails++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", cur.name, act, cur.val, cyc);
      end
    end
  end

  task automatic exp_push(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    e.cyc  = cyc;
    sbq.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_exec(input logic v, input logic [2:0] src, input logic [31:0] pce,
                            input logic [31:0] tgt, input logic [31:0] alu, input logic e,
                            input logic ptaken, input logic [31:0] ptarget);
    bus.ValidE      = v;
    bus.PCsrcE      = src;
    bus.PCE         = pce;
    bus.PCPlus4E    = pce + 32'd4;
    bus.PCTargetE   = tgt;
    bus.ALUResult   = alu;
    bus.eq          = e;
    bus.PredTakenE  = ptaken;
    bus.PredTargetE = ptarget;
  endtask

  task automatic idle();
    drive_exec(1'b0, NEXT_PC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic exp_lookup(input string name, input logic taken, input logic [31:0] tgt);
    exp_push({name, "_taken"}, S_PTAKEN, {31'd0, taken});
    exp_push({name, "_target"}, S_PTARGET, tgt);
  endtask

  task automatic exp_resolve(input string name, input logic misp, input logic [31:0] redir);
    exp_push({name, "_misp"}, S_MISP, {31'd0, misp});
    exp_push({name, "_redir"}, S_REDIR, redir);
  endtask

  task automatic exp_counts(input string name, input logic [31:0] b, input logic [31:0] m);
    exp_push({name, "_bcnt"}, S_BCNT, b);
    exp_push({name, "_mcnt"}, S_MCNT, m);
  endtask

  initial begin
    rst_n  = 1'b0;
    bus.PCF = 32'h100;
    idle();
    next_cycle();
    next_cycle();
    exp_lookup("rst", 1'b0, 32'h104);
    exp_counts("rst", 32'd0, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Taken EQ_TRUE miss allocates; same-cycle lookup still sees the old table.
    next_cycle();
    bus.PCF = 32'h100;
    drive_exec(1'b1, EQ_TRUE, 32'h100, 32'h80, 32'h0, 1'b1, 1'b0, 32'h104);
    exp_lookup("nobypass", 1'b0, 32'h104);
    exp_resolve("alloc", 1'b1, 32'h80);
    exp_push("alloc_bcnt", S_BCNT, 32'd0);
    next_cycle();
    idle();
    exp_lookup("after_alloc", 1'b1, 32'h80);
    exp_counts("after_alloc", 32'd1, 32'd1);

    // Two not-taken resolutions: 10 -> 01 -> 00.
    next_cycle();
    drive_exec(1'b1, EQ_TRUE, 32'h100, 32'h80, 32'h0, 1'b0, 1'b1, 32'h80);
    exp_resolve("nt1", 1'b1, 32'h104);
    next_cycle();
    drive_exec(1'b1, EQ_TRUE, 32'h100, 32'h80, 32'h0, 1'b0, 1'b0, 32'h104);
    exp_resolve("nt2", 1'b0, 32'h104);
    exp_lookup("ctr01", 1'b0, 32'h104);
    exp_counts("nt2", 32'd2, 32'd2);

    // JALR redirects to ALUResult and never trains.
    next_cycle();
    drive_exec(1'b1, JALR, 32'h200, 32'h300, 32'h2000, 1'b0, 1'b1, 32'h1FFC);
    exp_resolve("jalr", 1'b1, 32'h2000);
    exp_lookup("ctr00", 1'b0, 32'h104);
    exp_counts("jalr", 32'd3, 32'd2);
    next_cycle();
    idle();
    bus.PCF = 32'h200;
    exp_lookup("jalr_notrain", 1'b0, 32'h204);
    exp_counts("after_jalr", 32'd4, 32'd3);

    // Floor at 00, then climb with a new target; EQ_FALSE taken when eq=0.
    next_cycle();
    bus.PCF = 32'h100;
    drive_exec(1'b1, EQ_TRUE, 32'h100, 32'h88, 32'h0, 1'b1, 1'b0, 32'h104);
    exp_resolve("floor_up", 1'b1, 32'h88);
    next_cycle();
    drive_exec(1'b1, EQ_FALSE, 32'h100, 32'h88, 32'h0, 1'b0, 1'b0, 32'h104);
    exp_lookup("floor_ctr01", 1'b0, 32'h104);
    exp_resolve("eqf_taken", 1'b1, 32'h88);
    next_cycle();
    idle();
    exp_lookup("ctr10", 1'b1, 32'h88);
    exp_counts("climb", 32'd6, 32'd5);

    // Ceiling at 11: two jumps, one not-taken must leave it predicting taken.
    next_cycle();
    drive_exec(1'b1, UC_JUMP, 32'h100, 32'h88, 32'h0, 1'b0, 1'b1, 32'h88);
    exp_resolve("jmp_hit", 1'b0, 32'h88);
    next_cycle();
    drive_exec(1'b1, UC_JUMP, 32'h100, 32'h88, 32'h0, 1'b0, 1'b1, 32'h90);
    exp_resolve("jmp_badtgt", 1'b1, 32'h88);
    next_cycle();
    drive_exec(1'b1, EQ_TRUE, 32'h100, 32'h88, 32'h0, 1'b0, 1'b1, 32'h88);
    exp_resolve("ceil_down", 1'b1, 32'h104);
    next_cycle();
    idle();
    exp_lookup("ceil", 1'b1, 32'h88);
    exp_counts("ceil", 32'd9, 32'd7);

    // Aliasing at index 0: 0x140 replaces 0x100.
    next_cycle();
    drive_exec(1'b1, EQ_TRUE, 32'h140, 32'h400, 32'h0, 1'b1, 1'b0, 32'h144);
    exp_resolve("alias", 1'b1, 32'h400);
    next_cycle();
    idle();
    exp_lookup("alias_old", 1'b0, 32'h104);
    exp_counts("alias", 32'd10, 32'd8);
    next_cycle();
    bus.PCF = 32'h140;
    exp_lookup("alias_new", 1'b1, 32'h400);

    // UC_JUMP allocates strongly taken: one not-taken keeps it taken.
    next_cycle();
    drive_exec(1'b1, UC_JUMP, 32'h184, 32'h500, 32'h0, 1'b0, 1'b0, 32'h188);
    exp_resolve("jmp_alloc", 1'b1, 32'h500);
    next_cycle();
    drive_exec(1'b1, EQ_TRUE, 32'h184, 32'h500, 32'h0, 1'b0, 1'b1, 32'h500);
    exp_resolve("jmp_nt", 1'b1, 32'h188);
    next_cycle();
    idle();
    bus.PCF = 32'h184;
    exp_lookup("jmp_st", 1'b1, 32'h500);

    // Not-taken miss does not allocate.
    next_cycle();
    drive_exec(1'b1, EQ_FALSE, 32'h208, 32'h800, 32'h0, 1'b1, 1'b0, 32'h20C);
    exp_resolve("nt_miss", 1'b0, 32'h20C);
    next_cycle();
    idle();
    bus.PCF = 32'h208;
    exp_lookup("nt_noalloc", 1'b0, 32'h20C);

    // Undefined encoding behaves as NEXT_PC; bubbles never resolve or train.
    next_cycle();
    drive_exec(1'b1, 3'd7, 32'h240, 32'h600, 32'h0, 1'b1, 1'b0, 32'h244);
    exp_resolve("undef", 1'b0, 32'h244);
    next_cycle();
    drive_exec(1'b0, UC_JUMP, 32'h300, 32'h700, 32'h0, 1'b0, 1'b0, 32'h304);
    exp_push("bubble_misp", S_MISP, 32'd0);
    next_cycle();
    idle();
    bus.PCF = 32'h300;
    exp_lookup("bubble_notrain", 1'b0, 32'h304);
    exp_counts("pre_rst", 32'd13, 32'd10);

    // Reset mid-run with a would-be training jump on the bus.
    next_cycle();
    rst_n = 1'b0;
    bus.PCF = 32'h184;
    drive_exec(1'b1, UC_JUMP, 32'h100, 32'h900, 32'h0, 1'b0, 1'b0, 32'h104);
    exp_lookup("midrst", 1'b0, 32'h188);
    exp_counts("midrst", 32'd0, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    idle();
    bus.PCF = 32'h100;
    exp_lookup("post_rst", 1'b0, 32'h104);
    exp_counts("post_rst", 32'd0, 32'd0);

    next_cycle();
    next_cycle();
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
